// File: rtl/expr_scan_pkg.sv
// rtl/expr_scan_pkg.sv - shared state encoding and default sizing for the truth-table scanner
package expr_scan_pkg;

    localparam int DEFAULT_N_IN = 4;
    localparam int TT_DEPTH     = 2 ** DEFAULT_N_IN;
    localparam int IDX_W        = DEFAULT_N_IN;
    localparam int CNT_W        = $clog2(TT_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        EMIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/expr_truth_table_scanner.sv
// rtl/expr_truth_table_scanner.sv - sweeps all input combinations of an expression and streams its minterms
module expr_truth_table_scanner
    import expr_scan_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      drive,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   truth_table,
    output logic [N_IN:0]        ones_count,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N_IN-1:0]      m_index,
    output logic                 m_last
);

    localparam int DEPTH = 2 ** N_IN;

    state_t            r_state;
    state_t            w_next;
    logic [N_IN-1:0]   r_idx;
    logic [N_IN-1:0]   r_ptr;
    logic [N_IN-1:0]   r_drive;
    logic [3:0]        r_settle;
    logic [DEPTH-1:0]  r_tt;
    logic [N_IN:0]     r_ones;

    logic w_hold_done;
    logic w_idx_last;
    logic w_ptr_last;
    logic w_ptr_set;
    logic w_none_above;
    logic w_emit_valid;

    assign w_hold_done  = (r_settle == 4'(SETTLE));
    assign w_idx_last   = &r_idx;
    assign w_ptr_last   = &r_ptr;
    assign w_ptr_set    = r_tt[r_ptr];
    // No set bit above ptr means this minterm is the final one in the stream
    assign w_none_above = (((r_tt >> r_ptr) >> 1) == '0);
    assign w_emit_valid = (r_state == EMIT) && w_ptr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (w_hold_done && w_idx_last) w_next = EMIT;
            EMIT: begin
                if (w_ptr_set) begin
                    if (m_ready && w_none_above) w_next = FINISH;
                end else if (w_ptr_last) begin
                    w_next = FINISH;
                end
            end
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_ptr    <= '0;
            r_drive  <= '0;
            r_settle <= '0;
            r_tt     <= '0;
            r_ones   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tt     <= '0;
                        r_ones   <= '0;
                        r_idx    <= '0;
                        r_settle <= '0;
                        r_drive  <= '0;
                    end
                end
                SCAN: begin
                    if (w_hold_done) begin
                        r_tt[r_idx] <= y_in;
                        r_ones      <= r_ones + {{N_IN{1'b0}}, y_in};
                        r_settle    <= '0;
                        if (w_idx_last) begin
                            r_ptr   <= '0;
                            r_drive <= '0;
                        end else begin
                            r_idx   <= r_idx + N_IN'(1);
                            r_drive <= r_idx + N_IN'(1);
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                EMIT: begin
                    // Zeros advance unconditionally; a set bit waits for the handshake
                    if ((!w_ptr_set || m_ready) && !w_ptr_last) begin
                        r_ptr <= r_ptr + N_IN'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign drive       = r_drive;
    assign busy        = (r_state == SCAN) || (r_state == EMIT);
    assign done        = (r_state == FINISH);
    assign truth_table = r_tt;
    assign ones_count  = r_ones;
    assign m_valid     = w_emit_valid;
    assign m_index     = w_emit_valid ? r_ptr : '0;
    assign m_last      = w_emit_valid && w_none_above;

endmodule
